// File: rtl/aduna_acumulator_if.sv
// Handshake and data bundle between the aduna adder side and the accumulator.
// The master drives operands and handshake requests; the slave is the accumulator.
interface aduna_acumulator_if #(
    parameter int unsigned ACC_W = 8
);
    logic             start;
    logic [3:0]       s;
    logic             c4;
    logic             in_valid;
    logic             in_ready;
    logic             out_ready;
    logic             out_valid;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [3:0]       count;

    modport master (
        output start, s, c4, in_valid, out_ready,
        input  in_ready, out_valid, acc, ovf, count
    );

    modport slave (
        input  start, s, c4, in_valid, out_ready,
        output in_ready, out_valid, acc, ovf, count
    );
endinterface

// File: rtl/aduna_acumulator.sv
// Sums N_OPS adder results {c4,s} into an ACC_W-bit register with a sticky overflow flag,
// then presents the total on a valid/ready handshake.
module aduna_acumulator #(
    parameter int unsigned N_OPS = 4,
    parameter int unsigned ACC_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    aduna_acumulator_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(N_OPS - 1);

    state_t           r_state;
    state_t           w_next;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [3:0]       r_count;
    logic [ACC_W:0]   w_sum;
    logic             w_xfer;

    // One extra bit on the adder captures the carry out of the accumulator's MSB.
    assign w_sum  = {1'b0, r_acc} + {{(ACC_W - 4){1'b0}}, bus.c4, bus.s};
    assign w_xfer = (r_state == S_ACCUM) && bus.in_valid;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_ACCUM;
            S_ACCUM: if (w_xfer && (r_count == LAST_IDX)) w_next = S_HOLD;
            S_HOLD:  if (bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && bus.start) begin
                r_acc   <= '0;
                r_ovf   <= 1'b0;
                r_count <= '0;
            end else if (w_xfer) begin
                r_acc   <= w_sum[ACC_W-1:0];
                r_ovf   <= r_ovf | w_sum[ACC_W];
                r_count <= r_count + 4'd1;
            end
        end
    end

    assign bus.in_ready  = (r_state == S_ACCUM);
    assign bus.out_valid = (r_state == S_HOLD);
    assign bus.acc       = r_acc;
    assign bus.ovf       = r_ovf;
    assign bus.count     = r_count;

endmodule

// File: tb/tb_aduna_acumulator.sv
// Randomized scoreboard bench for aduna_acumulator: two instances (N_OPS=4 and N_OPS=9)
// checked against an arithmetic model of the run total.
module tb_aduna_acumulator;

    localparam int unsigned ACC_W = 8;
    localparam int unsigned MOD   = 256;

    typedef struct {
        int unsigned acc;
        int unsigned ovf;
        int unsigned cnt;
        int unsigned cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic        start;
    logic [3:0]  s;
    logic        c4;
    logic        in_valid;
    logic        out_ready;
    int unsigned cyc;
    int unsigned n_tests;
    int unsigned n_fail;
    exp_t        q0[$];
    exp_t        q1[$];
    bit          prev0;
    bit          prev1;

    aduna_acumulator_if #(.ACC_W(ACC_W)) bus0 ();
    aduna_acumulator_if #(.ACC_W(ACC_W)) bus1 ();

    aduna_acumulator #(.N_OPS(4), .ACC_W(ACC_W)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    aduna_acumulator #(.N_OPS(9), .ACC_W(ACC_W)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // Shared operand bus; handshake requests steered to the selected instance only.
    assign bus0.start     = start & ~sel;
    assign bus0.in_valid  = in_valid & ~sel;
    assign bus0.out_ready = out_ready & ~sel;
    assign bus0.s         = s;
    assign bus0.c4        = c4;
    assign bus1.start     = start & sel;
    assign bus1.in_valid  = in_valid & sel;
    assign bus1.out_ready = out_ready & sel;
    assign bus1.s         = s;
    assign bus1.c4        = c4;

    logic [ACC_W-1:0] m_acc;
    logic             m_ovf;
    logic [3:0]       m_count;
    logic             m_in_ready;
    logic             m_out_valid;
    assign m_acc       = sel ? bus1.acc       : bus0.acc;
    assign m_ovf       = sel ? bus1.ovf       : bus0.ovf;
    assign m_count     = sel ? bus1.count     : bus0.count;
    assign m_in_ready  = sel ? bus1.in_ready  : bus0.in_ready;
    assign m_out_valid = sel ? bus1.out_valid : bus0.out_valid;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors: each rising out_valid pops one expected run result.
    always @(negedge clk) begin : mon0
        exp_t e;
        if (bus0.out_valid === 1'b1 && !prev0) begin
            if (q0.size() == 0) begin
                chk("mon0_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                chk("mon0_acc", 32'(bus0.acc), e.acc);
                chk("mon0_ovf", 32'(bus0.ovf), e.ovf);
                chk("mon0_count", 32'(bus0.count), e.cnt);
                chk("mon0_latency_cycle", cyc, e.cyc);
            end
        end
        prev0 = (bus0.out_valid === 1'b1);
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (bus1.out_valid === 1'b1 && !prev1) begin
            if (q1.size() == 0) begin
                chk("mon1_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("mon1_acc", 32'(bus1.acc), e.acc);
                chk("mon1_ovf", 32'(bus1.ovf), e.ovf);
                chk("mon1_count", 32'(bus1.count), e.cnt);
                chk("mon1_latency_cycle", cyc, e.cyc);
            end
        end
        prev1 = (bus1.out_valid === 1'b1);
    end

    // One full run on the selected instance: start, n operands, HOLD, handshake.
    task automatic run(input int unsigned n, input bit rnd, input logic [4:0] fix,
                       input int unsigned gap_max, input int unsigned hold,
                       input bit pulse, input bit hs_start);
        int unsigned total;
        int unsigned gaps;
        logic [4:0]  op;
        exp_t        e;
        total = 0;
        @(negedge clk);
        start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_ready", 32'(m_in_ready), 1);
        chk("start_acc_clear", 32'(m_acc), 0);
        chk("start_ovf_clear", 32'(m_ovf), 0);
        chk("start_count_clear", 32'(m_count), 0);
        for (int unsigned i = 0; i < n; i++) begin
            gaps = (gap_max == 0) ? 0 : $urandom_range(gap_max, 0);
            for (int unsigned g = 0; g < gaps; g++) begin
                in_valid = 1'b0; {c4, s} = 5'($urandom);
                start = 1'($urandom); out_ready = 1'($urandom);
                @(negedge clk);
                chk("gap_in_ready", 32'(m_in_ready), 1);
                chk("gap_acc_hold", 32'(m_acc), total % MOD);
                chk("gap_count_hold", 32'(m_count), i);
            end
            op = rnd ? 5'($urandom) : fix;
            {c4, s} = op; in_valid = 1'b1;
            start = 1'($urandom); out_ready = 1'($urandom);
            @(posedge clk);
            #1;
            total += 32'(op);
            start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
            if (i == n - 1) begin
                e.acc = total % MOD;
                e.ovf = (total >= MOD) ? 1 : 0;
                e.cnt = n;
                e.cyc = cyc;
                if (sel) q1.push_back(e); else q0.push_back(e);
            end
            @(negedge clk);
            if (i != n - 1) begin
                chk("accum_count", 32'(m_count), i + 1);
                chk("accum_acc", 32'(m_acc), total % MOD);
            end
        end
        for (int unsigned h = 0; h < hold; h++) begin
            if (pulse) begin
                start = 1'($urandom); in_valid = 1'($urandom); {c4, s} = 5'($urandom);
            end
            @(negedge clk);
            chk("hold_out_valid", 32'(m_out_valid), 1);
            chk("hold_in_ready", 32'(m_in_ready), 0);
            chk("hold_acc", 32'(m_acc), total % MOD);
            chk("hold_ovf", 32'(m_ovf), (total >= MOD) ? 1 : 0);
            chk("hold_count", 32'(m_count), n);
        end
        start = hs_start; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b0;
        chk("idle_out_valid", 32'(m_out_valid), 0);
        chk("idle_in_ready", 32'(m_in_ready), 0);
        chk("idle_acc_kept", 32'(m_acc), total % MOD);
        if (hs_start) begin
            repeat (3) begin
                @(negedge clk);
                chk("hs_start_ignored", 32'(m_in_ready), 0);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
        $fatal(1);
    end

    initial begin
        cyc = 0; n_tests = 0; n_fail = 0; prev0 = 0; prev1 = 0;
        sel = 1'b0; start = 1'b0; s = '0; c4 = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        for (int unsigned k = 0; k < 2; k++) begin
            sel = k[0];
            chk("reset_acc", 32'(m_acc), 0);
            chk("reset_ovf", 32'(m_ovf), 0);
            chk("reset_count", 32'(m_count), 0);
            chk("reset_in_ready", 32'(m_in_ready), 0);
            chk("reset_out_valid", 32'(m_out_valid), 0);
        end
        sel = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back, gapped, backpressured, and start-in-handshake runs.
        run(4, 1'b0, 5'b0_1001, 0, 0, 1'b0, 1'b0);
        run(4, 1'b0, 5'b0_1001, 0, 0, 1'b0, 1'b0);
        run(4, 1'b0, 5'b0_1001, 3, 0, 1'b0, 1'b0);
        run(4, 1'b1, 5'd0, 0, 10, 1'b1, 1'b0);
        run(4, 1'b1, 5'd0, 1, 2, 1'b0, 1'b1);

        // Reset mid-run after two operands of 9.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) begin
            {c4, s} = 5'b0_1001; in_valid = 1'b1;
            @(negedge clk);
        end
        chk("midrun_acc", 32'(m_acc), 18);
        rst_n = 1'b0; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("midrun_rst_acc", 32'(m_acc), 0);
        chk("midrun_rst_count", 32'(m_count), 0);
        chk("midrun_rst_in_ready", 32'(m_in_ready), 0);
        chk("midrun_rst_out_valid", 32'(m_out_valid), 0);
        rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        run(4, 1'b1, 5'd0, 0, 0, 1'b0, 1'b0);

        for (int unsigned r = 0; r < 15; r++)
            run(4, 1'b1, 5'd0, 2, $urandom_range(3, 0), 1'b1, 1'($urandom));

        // Nine-operand instance: forced overflow, then cleared by the next start.
        sel = 1'b1;
        @(negedge clk);
        run(9, 1'b0, 5'b1_1111, 0, 2, 1'b1, 1'b0);
        chk("ovf_kept_in_idle", 32'(m_ovf), 1);
        for (int unsigned r = 0; r < 8; r++)
            run(9, 1'b1, 5'd0, 2, $urandom_range(3, 0), 1'b1, 1'($urandom));

        repeat (5) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aduna_acumulator.md
Name: aduna_acumulator

Overview:
Downstream stage of the 4-bit adder `aduna`. It consumes the adder's sum `s` and carry-out `c4` as a 5-bit value, and accumulates N_OPS accepted results into an ACC_W-bit register. It then presents the total with a valid/ready handshake and a sticky overflow flag. This provides the sequential multi-operand summation path on top of the combinational adder.

Parameters:
N_OPS, 4, number of adder results accumulated per run; legal range 1..15.
ACC_W, 8, accumulator width in bits; legal range 5..16.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
start  input  1  one-cycle pulse that begins a run; honoured only in IDLE.
s  input  4  sum bits from aduna.
c4  input  1  carry-out from aduna.
in_valid  input  1  upstream asserts that s/c4 hold a result to consume.
in_ready  output  1  block will accept s/c4 this cycle.
out_ready  input  1  downstream accepts the result.
out_valid  output  1  acc/ovf hold a completed run result.
acc  output  ACC_W  accumulated sum.
ovf  output  1  sticky overflow, set if any addition carried out of ACC_W bits.
count  output  4  number of results accepted in the current run.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE.
  - acc=0, ovf=0, count=0, in_ready=0, out_valid=0.
  - Reset overrides all other inputs, including mid-run and mid-HOLD; any partial sum is discarded.
- States: IDLE, ACCUM, HOLD. All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- IDLE:
  - in_ready=0, out_valid=0; acc/ovf keep the last result.
  - start=1 → next edge: acc=0, ovf=0, count=0, state=ACCUM.
- ACCUM:
  - in_ready=1.
  - A transfer occurs on any edge with in_valid=1.
  - On a transfer:
    - operand = {c4,s}, zero-extended to ACC_W bits (range 0..31).
    - acc <= (acc + operand) mod 2^ACC_W.
    - ovf <= ovf | carry out of bit ACC_W-1.
    - count <= count+1.
  - No transfer → all registers hold. Gaps in in_valid are allowed without limit.
  - Transfer while count==N_OPS-1 → the accumulation completes on that same edge and state=HOLD.
  - start is ignored.
- HOLD:
  - out_valid=1, in_ready=0; acc, ovf and count are frozen (count==N_OPS).
  - out_ready=1 → next edge: state=IDLE, out_valid=0.
  - out_ready=0 → hold indefinitely.
  - start is ignored, including when it coincides with out_ready=1; a new start must arrive while in IDLE.
- Latency:
  - out_valid rises exactly one cycle after the edge that accepted the N_OPS-th result.
  - The minimum run is 1 (start) + N_OPS + 1 (handshake) cycles.
- Simultaneous events:
  - rst_n=0 wins over start, in_valid and out_ready.
  - In ACCUM, in_valid and out_ready together → only the transfer is acted on.
- Wrap-around:
  - acc wraps modulo 2^ACC_W; ovf records any wrap and stays 1 until the next start or reset.
- count is reset to 0 on start and on reset only. It is never wrapped, because N_OPS ≤ 15.

Test Plan:
1. Defaults: reset, start, feed s=1001/c4=0 four times back-to-back → out_valid rises one cycle after the 4th transfer; acc=0x24 (36), ovf=0, count=4.
2. Gapped input: same run with in_valid low for 3 cycles between each operand → identical result (acc=36); in_ready=1 throughout ACCUM; no extra accumulation during gaps.
3. Overflow: N_OPS=9, ACC_W=8, feed {c4,s}=1_1111 (31) nine times → acc=0x17 (279-256=23), ovf=1; next start clears acc and ovf to 0.
4. Backpressure: hold out_ready=0 for 10 cycles in HOLD while pulsing start and in_valid → acc, ovf and count unchanged, in_ready=0; out_ready=1 → IDLE the next cycle with acc retained.
5. Reset mid-run: after 2 of 4 transfers (acc=18), drive rst_n=0 for one edge → acc=0, count=0, state IDLE, in_ready=0; a new start runs a clean 4-operand sum.
6. Start in the HOLD→IDLE handshake cycle is ignored → block stays in IDLE until a fresh start pulse.
